// File: rtl/ioctl_upload_pkg.sv
// Shared types and helpers for the ioctl upload (HPS read) return path.
// Latency: n/a (types and a pure combinational helper only).
// Backpressure: n/a.
//
// Contents:
//   upl_state_t  - reader FSM state encoding
//   FILL_DEFAULT - byte returned for addresses past the image end
//   in_range()   - byte-address vs. image-size compare
package ioctl_upload_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FETCH0   = 2'd1,
    CAP0     = 2'd2,
    CAP_LAST = 2'd3
  } upl_state_t;

  localparam logic [7:0] FILL_DEFAULT = 8'hFF;

  // Callers widen both operands to 32 bits, so an address that carried out of
  // the dpram address width compares as out of range instead of wrapping.
  function automatic logic in_range(input logic [31:0] i_addr, input logic [31:0] i_size);
    return (i_addr < i_size);
  endfunction

endpackage

// File: rtl/ioctl_upload_reader.sv
// Serves HPS ioctl upload reads from an 8-bit dpram, packing 1 or 2 bytes little-endian onto ioctl_din.
// Latency: ioctl_wait is high for 4 cycles (DW=16) or 3 cycles (DW=8), counting the strobe cycle.
// Backpressure: ioctl_wait stalls hps_io; a strobe while busy is dropped, and losing ioctl_upload aborts.
//
// Ports:
//   clk_sys, reset         - system clock, synchronous active-high reset
//   ioctl_upload           - level, upload session active
//   ioctl_rd               - one-cycle read strobe
//   ioctl_addr[24:0]       - request byte address (bit0 ignored for DW=16, bits >= AW ignored)
//   ioctl_din[DW-1:0]      - returned data, valid once ioctl_wait drops after a request
//   ioctl_wait             - stall towards hps_io (combinational, high in the strobe cycle)
//   size[AW:0]             - valid image length in bytes
//   mem_addr, mem_rd       - registered dpram address / read enable
//   mem_q[7:0]             - dpram data, one cycle after mem_addr
//   busy                   - FSM not idle
module ioctl_upload_reader
  import ioctl_upload_pkg::*;
#(
  parameter int         AW        = 13,
  parameter int         DW        = 16,
  parameter logic [7:0] FILL_BYTE = FILL_DEFAULT
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          ioctl_upload,
  input  logic          ioctl_rd,
  input  logic [24:0]   ioctl_addr,
  output logic [DW-1:0] ioctl_din,
  output logic          ioctl_wait,
  input  logic [AW:0]   size,
  output logic [AW-1:0] mem_addr,
  output logic          mem_rd,
  input  logic [7:0]    mem_q,
  output logic          busy
);

  upl_state_t    r_state;
  logic [AW-1:0] r_base;
  logic          r_fill0;
  logic          r_fill1;
  logic [DW-1:0] r_din;
  logic [AW-1:0] r_mem_addr;
  logic          r_mem_rd;

  logic [AW-1:0] w_base;
  logic [AW:0]   w_base_p1;
  logic          w_base_ok;
  logic          w_p1_ok;
  logic          w_last_fill;
  logic          w_start;
  logic          w_addr_unused;

  // For 16-bit transfers a request always covers an aligned byte pair.
  assign w_base    = {ioctl_addr[AW-1:1], (DW == 16) ? 1'b0 : ioctl_addr[0]};
  // One extra bit so base+1 overflowing the address space reads as out of range.
  assign w_base_p1 = {1'b0, r_base} + {{AW{1'b0}}, 1'b1};
  assign w_base_ok = in_range(32'(w_base), 32'(size));
  assign w_p1_ok   = in_range(32'(w_base_p1), 32'(size));

  // The last captured byte belongs to the second fetch only in 16-bit mode.
  assign w_last_fill = (DW == 16) ? r_fill1 : r_fill0;

  assign w_start       = ioctl_rd & ioctl_upload & (r_state == IDLE);
  assign w_addr_unused = ^ioctl_addr[24:AW];

  assign busy       = (r_state != IDLE);
  assign ioctl_wait = busy | w_start;
  assign ioctl_din  = r_din;
  assign mem_addr   = r_mem_addr;
  assign mem_rd     = r_mem_rd;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_state    <= IDLE;
      r_base     <= '0;
      r_fill0    <= 1'b0;
      r_fill1    <= 1'b0;
      r_din      <= '0;
      r_mem_addr <= '0;
      r_mem_rd   <= 1'b0;
    end else if ((r_state != IDLE) && !ioctl_upload) begin
      // Session dropped mid-request: abandon it, leave the last data on ioctl_din.
      r_state  <= IDLE;
      r_mem_rd <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_base     <= w_base;
            r_mem_addr <= w_base;
            r_mem_rd   <= w_base_ok;
            r_fill0    <= ~w_base_ok;
            r_state    <= FETCH0;
          end
        end

        FETCH0: begin
          if (DW == 16) begin
            r_mem_addr <= w_base_p1[AW-1:0];
            r_mem_rd   <= w_p1_ok;
            r_fill1    <= ~w_p1_ok;
            r_state    <= CAP0;
          end else begin
            r_state <= CAP_LAST;
          end
        end

        CAP0: begin
          r_din[7:0] <= r_fill0 ? FILL_BYTE : mem_q;
          r_mem_rd   <= 1'b0;
          r_state    <= CAP_LAST;
        end

        CAP_LAST: begin
          // Top byte for DW=16, the only byte for DW=8.
          r_din[DW-1:DW-8] <= w_last_fill ? FILL_BYTE : mem_q;
          r_mem_rd         <= 1'b0;
          r_state          <= IDLE;
        end

        default: begin
          r_state  <= IDLE;
          r_mem_rd <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ioctl_upload_reader.sv
// Bench for ioctl_upload_reader: one DW=16 and one DW=8 instance, each with a dpram model.
// Expected read data is queued at request time; per-instance monitors pop it when ioctl_wait falls.
module tb_ioctl_upload_reader;

  logic        clk = 1'b0;
  logic        reset;
  logic        rd_cmd;
  logic        up_cmd;
  logic [24:0] addr_cmd;
  logic        cur8;

  logic [13:0] size16, size8;
  logic [15:0] din16;
  logic [7:0]  din8;
  logic        wait16, wait8, busy16, busy8, mr16, mr8;
  logic [12:0] ma16, ma8;
  logic [7:0]  q16m, q8m;
  logic        rd16, rd8;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] q16[$];
  logic [7:0]  q8[$];
  logic [15:0] last16;
  logic        pw16 = 1'b0, pw8 = 1'b0;
  logic [15:0] e16;
  logic [7:0]  e8;

  logic        cw, cmr;
  logic [12:0] cma;
  logic [2:0][12:0] ma_log;
  logic [2:0]       mr_log;

  always #5 clk = ~clk;

  assign rd16 = rd_cmd & ~cur8;
  assign rd8  = rd_cmd & cur8;
  assign cw   = cur8 ? wait8 : wait16;
  assign cma  = cur8 ? ma8 : ma16;
  assign cmr  = cur8 ? mr8 : mr16;

  ioctl_upload_reader #(.AW(13), .DW(16)) u16 (
    .clk_sys(clk), .reset(reset), .ioctl_upload(up_cmd), .ioctl_rd(rd16),
    .ioctl_addr(addr_cmd), .ioctl_din(din16), .ioctl_wait(wait16), .size(size16),
    .mem_addr(ma16), .mem_rd(mr16), .mem_q(q16m), .busy(busy16)
  );

  ioctl_upload_reader #(.AW(13), .DW(8)) u8 (
    .clk_sys(clk), .reset(reset), .ioctl_upload(up_cmd), .ioctl_rd(rd8),
    .ioctl_addr(addr_cmd), .ioctl_din(din8), .ioctl_wait(wait8), .size(size8),
    .mem_addr(ma8), .mem_rd(mr8), .mem_q(q8m), .busy(busy8)
  );

  // dpram models: mem16[i] = i[7:0], mem8[i] = i[7:0] ^ 8'hA5; registered read.
  always @(posedge clk) begin
    q16m <= ma16[7:0];
    q8m  <= ma8[7:0] ^ 8'hA5;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, expv);
    end
  endtask

  always @(negedge clk) begin
    if (pw16 && !wait16) begin
      if (q16.size() == 0) chk("din16_unexpected", 32'd1, 32'd0);
      else begin
        e16 = q16.pop_front();
        chk("din16", 32'(din16), 32'(e16));
      end
    end
    pw16 = wait16;
  end

  always @(negedge clk) begin
    if (pw8 && !wait8) begin
      if (q8.size() == 0) chk("din8_unexpected", 32'd1, 32'd0);
      else begin
        e8 = q8.pop_front();
        chk("din8", 32'(din8), 32'(e8));
      end
    end
    pw8 = wait8;
  end

  // Issue one request; returns mem_addr/mem_rd seen in the three cycles after the strobe.
  task automatic run_rd(input bit d8, input logic [24:0] a, input logic [15:0] expv,
                        input bit dbl, input int exp_len,
                        output logic [2:0][12:0] ma, output logic [2:0] mr);
    int len;
    ma = '0;
    mr = '0;
    cur8 = d8;
    if (d8) q8.push_back(expv[7:0]);
    else begin
      q16.push_back(expv);
      last16 = expv;
    end
    @(negedge clk);
    addr_cmd = a;
    rd_cmd   = 1'b1;
    up_cmd   = 1'b1;
    #1;
    chk("strobe_wait", 32'(cw), 32'd1);
    @(posedge clk);
    #1;
    rd_cmd = dbl;
    if (dbl) addr_cmd = a ^ 25'h4;
    len = 1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i < 3) begin
        ma[i] = cma;
        mr[i] = cmr;
      end
      if (i == 1) rd_cmd = 1'b0;
      if (cw) len++;
      else break;
    end
    rd_cmd = 1'b0;
    chk("wait_len", 32'(len), 32'(exp_len));
  endtask

  initial begin
    reset    = 1'b1;
    rd_cmd   = 1'b0;
    up_cmd   = 1'b0;
    addr_cmd = '0;
    cur8     = 1'b0;
    size16   = 14'd8;
    size8    = 14'h2000;
    last16   = 16'h0;
    repeat (3) @(posedge clk);
    #1;
    reset  = 1'b0;
    up_cmd = 1'b1;
    @(negedge clk);
    chk("rst_din16", 32'(din16), 32'd0);
    chk("rst_din8", 32'(din8), 32'd0);
    chk("rst_wait", 32'(wait16), 32'd0);
    chk("rst_busy", 32'(busy16), 32'd0);
    chk("rst_mem_addr", 32'(ma16), 32'd0);
    chk("rst_mem_rd", 32'(mr16), 32'd0);

    // DW=16, size 8
    run_rd(1'b0, 25'd2, 16'h0302, 1'b0, 4, ma_log, mr_log);
    chk("t1_ma0", 32'(ma_log[0]), 32'd2);
    chk("t1_mr0", 32'(mr_log[0]), 32'd1);
    chk("t1_ma1", 32'(ma_log[1]), 32'd3);
    chk("t1_mr1", 32'(mr_log[1]), 32'd1);
    chk("t1_mr2", 32'(mr_log[2]), 32'd0);
    run_rd(1'b0, 25'd3, 16'h0302, 1'b0, 4, ma_log, mr_log);
    chk("odd_ma0", 32'(ma_log[0]), 32'd2);
    run_rd(1'b0, 25'd6, 16'h0706, 1'b0, 4, ma_log, mr_log);
    run_rd(1'b0, 25'h1FFE002, 16'h0302, 1'b0, 4, ma_log, mr_log);
    chk("hibits_ma0", 32'(ma_log[0]), 32'd2);

    // DW=16, size 5: top byte past the end
    size16 = 14'd5;
    run_rd(1'b0, 25'd4, 16'hFF04, 1'b0, 4, ma_log, mr_log);
    chk("t2_mr0", 32'(mr_log[0]), 32'd1);
    chk("t2_ma1", 32'(ma_log[1]), 32'd5);
    chk("t2_mr1", 32'(mr_log[1]), 32'd0);

    // size 0: everything fills
    size16 = 14'd0;
    run_rd(1'b0, 25'd0, 16'hFFFF, 1'b0, 4, ma_log, mr_log);
    chk("sz0_mr0", 32'(mr_log[0]), 32'd0);
    chk("sz0_mr1", 32'(mr_log[1]), 32'd0);
    size16 = 14'd8;

    // DW=8, full-size image
    run_rd(1'b1, 25'h1FFF, 16'h005A, 1'b0, 3, ma_log, mr_log);
    chk("t3_ma0", 32'(ma_log[0]), 32'h1FFF);
    chk("t3_mr0", 32'(mr_log[0]), 32'd1);
    run_rd(1'b1, 25'd0, 16'h00A5, 1'b0, 3, ma_log, mr_log);
    size8 = 14'h1FFF;
    run_rd(1'b1, 25'h1FFF, 16'h00FF, 1'b0, 3, ma_log, mr_log);
    chk("d8_edge_mr0", 32'(mr_log[0]), 32'd0);
    cur8 = 1'b0;

    // Second strobe while busy is dropped
    run_rd(1'b0, 25'd2, 16'h0302, 1'b1, 4, ma_log, mr_log);
    chk("t5_ma0", 32'(ma_log[0]), 32'd2);
    chk("t5_ma1", 32'(ma_log[1]), 32'd3);
    repeat (3) @(negedge clk);
    chk("t5_no_second", 32'(busy16), 32'd0);

    // Strobe with upload low: no request
    @(negedge clk);
    addr_cmd = 25'd4;
    rd_cmd   = 1'b1;
    up_cmd   = 1'b0;
    #1;
    chk("norq_wait", 32'(wait16), 32'd0);
    @(posedge clk);
    #1;
    rd_cmd = 1'b0;
    up_cmd = 1'b1;
    @(negedge clk);
    chk("norq_busy", 32'(busy16), 32'd0);

    // Abort: upload drops one cycle after the strobe
    q16.push_back(last16);
    @(negedge clk);
    addr_cmd = 25'd6;
    rd_cmd   = 1'b1;
    up_cmd   = 1'b1;
    @(posedge clk);
    #1;
    rd_cmd = 1'b0;
    up_cmd = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("abort_busy", 32'(busy16), 32'd0);
    chk("abort_wait", 32'(wait16), 32'd0);
    chk("abort_mem_rd", 32'(mr16), 32'd0);
    chk("abort_din", 32'(din16), 32'(last16));
    up_cmd = 1'b1;

    // Reset during FETCH0
    q16.push_back(16'h0000);
    @(negedge clk);
    addr_cmd = 25'd2;
    rd_cmd   = 1'b1;
    @(posedge clk);
    #1;
    rd_cmd = 1'b0;
    reset  = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("t6_din", 32'(din16), 32'd0);
    chk("t6_busy", 32'(busy16), 32'd0);
    chk("t6_wait", 32'(wait16), 32'd0);
    chk("t6_mem_addr", 32'(ma16), 32'd0);
    chk("t6_mem_rd", 32'(mr16), 32'd0);
    run_rd(1'b0, 25'd4, 16'h0504, 1'b0, 4, ma_log, mr_log);

    repeat (3) @(negedge clk);
    chk("q16_drained", 32'(q16.size()), 32'd0);
    chk("q8_drained", 32'(q8.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
